// File: rtl/cpu_io_initiator_if.sv
// Request and external I/O bus signals of the IORQ initiator.
// The master modport is the initiator; the slave modport is the requester/responder side.
interface cpu_io_initiator_if;
    logic       req;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy;
    logic       ack;
    logic [7:0] rdata;
    logic [7:0] a;
    logic [7:0] cd_out;
    logic       cd_oe;
    logic [7:0] cd_in;
    logic       rd_iorq_n;
    logic       wr_iorq_n;

    modport master (
        input  req, req_wr, req_addr, req_wdata, cd_in,
        output busy, ack, rdata, a, cd_out, cd_oe, rd_iorq_n, wr_iorq_n
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, cd_in,
        input  busy, ack, rdata, a, cd_out, cd_oe, rd_iorq_n, wr_iorq_n
    );
endinterface

// File: rtl/cpu_io_initiator.sv
// Z80-style IORQ bus initiator: one transfer per request with programmable setup,
// strobe and hold phases, followed by a one-cycle acknowledge. All outputs are registered.
module cpu_io_initiator #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    cpu_io_initiator_if.master bus
);
    localparam int unsigned MaxSt     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES
                                                                       : STROBE_CYCLES;
    localparam int unsigned MaxCycles = (MaxSt > HOLD_CYCLES) ? MaxSt : HOLD_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StAck} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            wr_q;
    logic            busy_q;
    logic            ack_q;
    logic [7:0]      rdata_q;
    logic [7:0]      a_q;
    logic [7:0]      cd_out_q;
    logic            cd_oe_q;
    logic            rd_n_q;
    logic            wr_n_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            a_q      <= '0;
            cd_out_q <= '0;
            cd_oe_q  <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                // ACK accepts a new request exactly like IDLE for back-to-back transfers.
                StIdle, StAck: begin
                    if (bus.req) begin
                        wr_q     <= bus.req_wr;
                        a_q      <= bus.req_addr;
                        cd_out_q <= bus.req_wdata;
                        cd_oe_q  <= bus.req_wr;
                        busy_q   <= 1'b1;
                        cnt_q    <= SetupLd;
                        state_q  <= StSetup;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= StrobeLd;
                        wr_n_q  <= ~wr_q;
                        rd_n_q  <= wr_q;
                        state_q <= StStrobe;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StStrobe: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) begin
                            rdata_q <= bus.cd_in;
                        end
                        cnt_q   <= HoldLd;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        cd_oe_q <= 1'b0;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.a         = a_q;
    assign bus.cd_out    = cd_out_q;
    assign bus.cd_oe     = cd_oe_q;
    assign bus.rd_iorq_n = rd_n_q;
    assign bus.wr_iorq_n = wr_n_q;
endmodule

// File: tb/tb_cpu_io_initiator.sv
// Bench for cpu_io_initiator: scoreboarded reference model on a default-timing instance,
// plus a sweep of all S,T,H in {1,3} timing combinations.
module tb_cpu_io_initiator;
    localparam int S   = 1;
    localparam int T   = 2;
    localparam int H   = 1;
    localparam int SUM = S + T + H;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         e;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic rst_seen = 1'b0;
    bit   done_chk = 1'b0;

    cpu_io_initiator_if bus ();

    cpu_io_initiator #(
        .SETUP_CYCLES (S),
        .STROBE_CYCLES(T),
        .HOLD_CYCLES  (H)
    ) u_dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus.master)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model and responder: transfers are atomic events at acceptance.
    logic [7:0] ref_mem [256];
    logic [7:0] resp_mem[256];
    logic [7:0] junk_q = 8'h00;
    xfer_t      sb[$];
    int         free_at = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
        junk_q   <= 8'($urandom);
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) begin
                logic [7:0] v;
                v = 8'($urandom);
                ref_mem[i]  <= (i == 8'h99) ? 8'hA7 : v;
                resp_mem[i] <= (i == 8'h99) ? 8'hA7 : v;
            end
        end else if (rst) begin
            free_at <= 0;
        end else begin
            if (!bus.wr_iorq_n) begin
                resp_mem[bus.a] <= bus.cd_out;
            end
            if (bus.req && (cyc + 1 >= free_at)) begin
                xfer_t t;
                t.wr    = bus.req_wr;
                t.addr  = bus.req_addr;
                t.wdata = bus.req_wdata;
                t.rdata = bus.req_wr ? 8'h00 : ref_mem[bus.req_addr];
                t.e     = cyc + 1;
                if (bus.req_wr) begin
                    ref_mem[bus.req_addr] <= bus.req_wdata;
                end
                sb.push_back(t);
                free_at <= cyc + 1 + SUM + 1;
            end
        end
    end

    always_comb begin
        bus.cd_in = junk_q;
        if (!bus.rd_iorq_n) begin
            bus.cd_in = resp_mem[bus.a];
        end
    end

    // Monitor: compares every cycle against the transfer at the scoreboard head.
    int         rd_idx = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_rdata = 8'h00;

    always @(negedge clk) begin
        xfer_t h;
        bit    have, in_st, e_busy;
        int    o;
        if (rst_seen) begin
            chk("rst_a", int'(bus.a), 0);
            chk("rst_cd_out", int'(bus.cd_out), 0);
            chk("rst_cd_oe", int'(bus.cd_oe), 0);
            chk("rst_rd_n", int'(bus.rd_iorq_n), 1);
            chk("rst_wr_n", int'(bus.wr_iorq_n), 1);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_ack", int'(bus.ack), 0);
            chk("rst_rdata", int'(bus.rdata), 0);
            rd_idx     = sb.size();
            last_addr  = 8'h00;
            last_rdata = 8'h00;
        end else begin
            have = rd_idx < sb.size();
            o    = 0;
            h    = '{default: 0};
            if (have) begin
                h = sb[rd_idx];
                o = cyc - h.e;
            end
            in_st  = have && o >= S && o < S + T;
            e_busy = have && o < SUM;
            chk("busy", int'(bus.busy), int'(e_busy));
            chk("addr", int'(bus.a), int'(have ? h.addr : last_addr));
            chk("wr_n", int'(bus.wr_iorq_n), int'(!(in_st && h.wr)));
            chk("rd_n", int'(bus.rd_iorq_n), int'(!(in_st && !h.wr)));
            chk("cd_oe", int'(bus.cd_oe), int'(e_busy && h.wr));
            if (e_busy && h.wr) begin
                chk("cd_out", int'(bus.cd_out), int'(h.wdata));
            end
            chk("rdata", int'(bus.rdata),
                int'((have && !h.wr && o >= S + T) ? h.rdata : last_rdata));
            if (bus.ack) begin
                if (!have) begin
                    chk("spurious_ack", 1, 0);
                end else begin
                    chk("ack_latency", o, SUM);
                    last_addr = h.addr;
                    if (!h.wr) last_rdata = h.rdata;
                    rd_idx++;
                end
            end else if (have && o >= SUM) begin
                chk("ack_missing", 0, 1);
                last_addr = h.addr;
                if (!h.wr) last_rdata = h.rdata;
                rd_idx++;
            end
        end
        if (done_chk) begin
            chk("sb_drained", rd_idx, sb.size());
        end
    end

    a_excl_main: assert property (@(negedge clk) !(!bus.rd_iorq_n && !bus.wr_iorq_n));

    // Timing sweep: every instance sees the same continuous request stream.
    logic sweep_req = 1'b0;
    logic sweep_wr  = 1'b0;

    for (genvar g = 0; g < 8; g++) begin : g_sweep
        localparam int GS = (g % 2 == 1) ? 3 : 1;
        localparam int GT = ((g / 2) % 2 == 1) ? 3 : 1;
        localparam int GH = ((g / 4) % 2 == 1) ? 3 : 1;

        cpu_io_initiator_if sif ();
        int e_q     = 0;
        bit act_q   = 1'b0;
        int low_cnt = 0;

        assign sif.req       = sweep_req;
        assign sif.req_wr    = sweep_wr;
        assign sif.req_addr  = 8'h98 + 8'(g);
        assign sif.req_wdata = 8'h3C;
        assign sif.cd_in     = 8'h5A;

        cpu_io_initiator #(
            .SETUP_CYCLES (GS),
            .STROBE_CYCLES(GT),
            .HOLD_CYCLES  (GH)
        ) u_dut (
            .clk_i  (clk),
            .reset_i(rst),
            .bus    (sif.master)
        );

        always @(posedge clk) begin
            if (rst) begin
                act_q <= 1'b0;
            end else if (sweep_req && (!act_q || cyc + 1 >= e_q + GS + GT + GH + 1)) begin
                act_q <= 1'b1;
                e_q   <= cyc + 1;
            end
        end

        always @(negedge clk) begin
            int o;
            bit low;
            if (!rst_seen) begin
                o   = cyc - e_q;
                low = !sif.rd_iorq_n || !sif.wr_iorq_n;
                chk($sformatf("sweep%0d_strobe", g), int'(low),
                    int'(act_q && o >= GS && o < GS + GT));
                chk($sformatf("sweep%0d_ack", g), int'(sif.ack),
                    int'(act_q && o == GS + GT + GH));
                if (low) begin
                    low_cnt++;
                end else if (low_cnt != 0) begin
                    chk($sformatf("sweep%0d_width", g), low_cnt, GT);
                    low_cnt = 0;
                end
            end
        end

        a_excl: assert property (@(negedge clk) !(!sif.rd_iorq_n && !sif.wr_iorq_n));
    end

    task automatic drive(input bit r, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata);
        bus.req       = r;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        drive(1'b1, wr, addr, wdata);
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(1'b1, 8'h98, 8'h5A);
        repeat (6) @(negedge clk);
        issue(1'b0, 8'h99, 8'h00);
        repeat (6) @(negedge clk);

        // Second request lands in SETUP of the first and must be dropped.
        issue(1'b0, 8'h98, 8'h00);
        drive(1'b1, 1'b1, 8'h9A, 8'hEE);
        @(negedge clk);
        bus.req = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 2 == 0) drive(1'b1, 1'b1, 8'h9B, 8'h11);
            else            drive(1'b1, 1'b0, 8'h98, 8'h00);
            repeat (SUM) @(negedge clk);
        end
        bus.req = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 2) == 0, 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h98 + 8'($urandom_range(0, 3)),
                  8'($urandom));
        end
        bus.req = 1'b0;
        repeat (8) @(negedge clk);

        // Abort a read while its strobe is low.
        issue(1'b0, 8'h99, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        sweep_req = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            sweep_wr = 1'($urandom);
        end
        sweep_req = 1'b0;
        repeat (20) @(negedge clk);

        done_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
